// File: rtl/psum_requant_writer_pkg.sv
// Purpose: shared types and constants for the psum requantizing SRAM writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package psum_requant_writer_pkg;

  // Width of the programmable right-shift amount.
  localparam int SHIFT_BW = 4;

  // Default geometry: 16 channels packed 4 per output word.
  localparam int INPUT_CH = 16;
  localparam int PACK     = 4;

  // Number of output words produced per captured vector.
  function automatic int words_of(input int ch, input int pk);
    return ch / pk;
  endfunction

  localparam int WORDS = words_of(INPUT_CH, PACK);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/psum_requant_writer_requant_sat.sv
// Purpose: single-channel requantizer: signed psum -> bw-bit unsigned via shift + saturate.
// Latency: combinational.
// Backpressure: none (pure function of inputs).
//
// Ports:
//   x      signed psum for one channel
//   shift  arithmetic right-shift amount
//   q      saturated unsigned activation
// Build option: PSUM_REQUANT_ROUND_EN adds round-half-up before the shift.
module requant_sat
  import psum_requant_writer_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16
) (
  input  logic signed [psum_bw-1:0]  x,
  input  logic        [SHIFT_BW-1:0] shift,
  output logic        [bw-1:0]       q
);

  localparam logic [psum_bw:0] q_max = (psum_bw+1)'((1 << bw) - 1);

  // One extra bit of headroom so the rounding add cannot wrap.
  logic [psum_bw:0] shifted;

`ifdef PSUM_REQUANT_ROUND_EN
  logic [psum_bw:0] half;
  logic [psum_bw:0] biased;

  // (1 << shift) >> 1 is 2^(shift-1) for shift>0 and 0 for shift==0.
  assign half    = ({{psum_bw{1'b0}}, 1'b1} << shift) >> 1;
  assign biased  = {x[psum_bw-1], x} + half;
  assign shifted = biased >> shift;
`else
  assign shifted = {x[psum_bw-1], x} >> shift;
`endif

  // Negative inputs clamp to zero, so the shifts above only ever act on
  // non-negative values and a logical shift is equivalent to arithmetic.
  always_comb begin
    if (x[psum_bw-1]) begin
      q = '0;
    end else if (shifted > q_max) begin
      q = '1;
    end else begin
      q = shifted[bw-1:0];
    end
  end

endmodule

// File: rtl/psum_requant_writer.sv
// Purpose: capture an SFU psum vector, requantize per channel, drain packed words to SRAM.
// Latency: word 0 valid the cycle after an accepted load; one word per cycle when ready.
// Backpressure: out_ready=0 holds out_data/out_addr/out_valid; loads while busy are dropped (ovf).
//
// Ports:
//   clk, reset            clock, async active-low reset
//   psums_in, load        SFU vector and its capture strobe
//   shift, base_addr      requant shift and word-0 address, sampled at accepted load
//   out_valid/out_ready   write-port handshake; out_data packed word, out_addr write address
//   busy, done            drain in progress / one-cycle pulse after last word
//   ovf, ovf_clr          sticky dropped-load flag and its clear
// Build option: PSUM_REQUANT_ROUND_EN enables round-half-up in each channel requantizer.
module psum_requant_writer
  import psum_requant_writer_pkg::*;
#(
  parameter int bw       = 4,
  parameter int psum_bw  = 16,
  parameter int input_ch = INPUT_CH,
  parameter int pack     = PACK,
  parameter int addr_bw  = 11
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [psum_bw*input_ch-1:0] psums_in,
  input  logic                        load,
  input  logic [SHIFT_BW-1:0]         shift,
  input  logic [addr_bw-1:0]          base_addr,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [bw*pack-1:0]          out_data,
  output logic [addr_bw-1:0]          out_addr,
  output logic                        busy,
  output logic                        done,
  output logic                        ovf,
  input  logic                        ovf_clr
);

  localparam int n_words = words_of(input_ch, pack);
  localparam int w_bw    = (n_words > 1) ? $clog2(n_words) : 1;
  localparam logic [w_bw-1:0] last_w = w_bw'(n_words - 1);

  state_t state_q;
  state_t state_d;

  // Shadow vector viewed as one row of psums per output word.
  logic [n_words-1:0][pack*psum_bw-1:0] shadow_q;
  logic [SHIFT_BW-1:0]                  shift_q;
  logic [addr_bw-1:0]                   base_q;
  logic [w_bw-1:0]                      w_q;
  logic                                 done_q;
  logic                                 ovf_q;

  logic                    accept;
  logic                    hs;
  logic                    last_hs;
  logic [pack*psum_bw-1:0] cur_psums;
  logic [bw*pack-1:0]      cur_word;

  assign accept    = (state_q == ST_IDLE) & load;
  assign hs        = (state_q == ST_DRAIN) & out_ready;
  assign last_hs   = hs & (w_q == last_w);
  assign cur_psums = shadow_q[w_q];

  // Only one word's worth of requantizers; the word index selects the row.
  // Inputs are all registers, so the word stays stable across stalls.
  for (genvar j = 0; j < pack; j++) begin : g_lane
    requant_sat #(
      .bw      (bw),
      .psum_bw (psum_bw)
    ) u_sat (
      .x     (cur_psums[j*psum_bw +: psum_bw]),
      .shift (shift_q),
      .q     (cur_word[j*bw +: bw])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (load)    state_d = ST_DRAIN;
      ST_DRAIN: if (last_hs) state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  // Output logic; outputs read zero outside a drain.
  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    out_addr  = '0;
    if (state_q == ST_DRAIN) begin
      out_valid = 1'b1;
      busy      = 1'b1;
      out_data  = cur_word;
      out_addr  = base_q + addr_bw'(w_q);
    end
  end

  assign done = done_q;
  assign ovf  = ovf_q;

  // Datapath: capture, word counter, done pulse, sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q <= '0;
      shift_q  <= '0;
      base_q   <= '0;
      w_q      <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (accept) begin
        shadow_q <= psums_in;
        shift_q  <= shift;
        base_q   <= base_addr;
        w_q      <= '0;
      end else if (hs && !last_hs) begin
        w_q <= w_q + 1'b1;
      end

      done_q <= last_hs;

      // A dropped load wins over a same-cycle clear.
      if (load && (state_q == ST_DRAIN)) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_psum_requant_writer.sv
// Purpose: scoreboard bench for psum_requant_writer.
// Latency: n/a.
// Backpressure: drives out_ready patterns including stalls.
module tb_psum_requant_writer;

  localparam int BW      = 4;
  localparam int PSUM_BW = 16;
  localparam int CH      = 16;
  localparam int PACK    = 4;
  localparam int ABW     = 11;
  localparam int WORDS   = CH / PACK;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [PSUM_BW*CH-1:0] psums_in;
  logic                  load;
  logic [3:0]            shift;
  logic [ABW-1:0]        base_addr;
  logic                  out_valid;
  logic                  out_ready;
  logic [BW*PACK-1:0]    out_data;
  logic [ABW-1:0]        out_addr;
  logic                  busy;
  logic                  done;
  logic                  ovf;
  logic                  ovf_clr;

  always #5 clk = ~clk;

  psum_requant_writer dut (
    .clk       (clk),
    .reset     (reset),
    .psums_in  (psums_in),
    .load      (load),
    .shift     (shift),
    .base_addr (base_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  typedef struct packed {
    logic [ABW-1:0]     addr;
    logic [BW*PACK-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference requantizer written with integer division.
  function automatic int quant(input int x, input int sh);
    int v;
    if (x < 0) return 0;
`ifdef PSUM_REQUANT_ROUND_EN
    v = (x + ((1 << sh) / 2)) / (1 << sh);
`else
    v = x / (1 << sh);
`endif
    if (v > 15) v = 15;
    return v;
  endfunction

  function automatic void push_vec(input logic [PSUM_BW*CH-1:0] vec, input int sh, input int base);
    exp_t e;
    for (int w = 0; w < WORDS; w++) begin
      e.data = '0;
      for (int j = 0; j < PACK; j++) begin
        int ch;
        int x;
        ch = w * PACK + j;
        x  = int'($signed(vec[PSUM_BW*ch +: PSUM_BW]));
        e.data = e.data | (16'(quant(x, sh)) << (BW * j));
      end
      e.addr = ABW'((base + w) % 2048);
      sb.push_back(e);
    end
  endfunction

  function automatic logic [PSUM_BW*CH-1:0] rand_vec();
    logic [PSUM_BW*CH-1:0] v;
    for (int k = 0; k < CH; k++) v[PSUM_BW*k +: PSUM_BW] = 16'($urandom_range(0, 'h300));
    return v;
  endfunction

  // Called just after a rising edge; returns just after the edge that samples load.
  task automatic do_load(input logic [PSUM_BW*CH-1:0] vec, input logic [3:0] sh,
                         input logic [ABW-1:0] base, input bit expect_accept);
    psums_in  = vec;
    shift     = sh;
    base_addr = base;
    load      = 1'b1;
    if (expect_accept) push_vec(vec, int'(sh), int'(base));
    @(posedge clk); #1;
    load = 1'b0;
    for (int i = 0; i < 8; i++) psums_in[32*i +: 32] = $urandom();
    shift     = 4'($urandom_range(0, 15));
    base_addr = ABW'($urandom_range(0, 2047));
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq(tag, 32'(busy), 32'd0);
    check_eq({tag, "_left"}, 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // Compare every presented word against the scoreboard head; pop on handshake.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 32'(out_valid), 32'd0);
      end else begin
        check_eq("word_data", 32'(out_data), 32'(sb[0].data));
        check_eq("word_addr", 32'(out_addr), 32'(sb[0].addr));
        if (out_ready) begin
          void'(sb.pop_front());
          hs_cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PSUM_BW*CH-1:0] v;
    logic [15:0]           exp0;
    bit                    pat [4];
    int                    n;

    reset = 1'b0; load = 1'b0; psums_in = '0; shift = '0; base_addr = '0;
    out_ready = 1'b0; ovf_clr = 1'b0;
    #12;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy",  32'(busy),      32'd0);
    check_eq("rst_done",  32'(done),      32'd0);
    check_eq("rst_ovf",   32'(ovf),       32'd0);
    check_eq("rst_data",  32'(out_data),  32'd0);
    check_eq("rst_addr",  32'(out_addr),  32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Basic drain, latency and done timing.
    out_ready = 1'b1;
    hs_cnt = 0;
    for (int k = 0; k < CH; k++) v[PSUM_BW*k +: PSUM_BW] = 16'h0050;
    do_load(v, 4'd4, 11'h010, 1'b1);
    check_eq("a_valid", 32'(out_valid), 32'd1);
    check_eq("a_busy",  32'(busy),      32'd1);
    check_eq("a_data0", 32'(out_data),  32'h5555);
    check_eq("a_addr0", 32'(out_addr),  32'h010);
    repeat (4) begin @(posedge clk); #1; end
    check_eq("a_done",     32'(done),   32'd1);
    check_eq("a_busy_off", 32'(busy),   32'd0);
    check_eq("a_hs",       32'(hs_cnt), 32'd4);
    @(posedge clk); #1;
    check_eq("a_done_pulse", 32'(done), 32'd0);

    // Saturation, truncation/rounding, negative clamp.
    v = '0;
    for (int k = 4; k < CH; k++) v[PSUM_BW*k +: PSUM_BW] = 16'(k * 37);
    v[15:0]  = 16'h0400;
    v[31:16] = 16'h0003;
    v[47:32] = 16'h0008;
    v[63:48] = 16'hFFF0;
`ifdef PSUM_REQUANT_ROUND_EN
    exp0 = 16'h010F;
`else
    exp0 = 16'h000F;
`endif
    do_load(v, 4'd4, 11'h100, 1'b1);
    check_eq("b_word0", 32'(out_data), 32'(exp0));
    wait_idle("b_idle");

    // Stall pattern 1,0,0,1.
    hs_cnt = 0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_load(rand_vec(), 4'd3, 11'h200, 1'b1);
    for (int i = 0; i < 4; i++) begin
      out_ready = pat[i];
      @(posedge clk); #1;
      check_eq("c_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    wait_idle("c_idle");
    check_eq("c_hs", 32'(hs_cnt), 32'd4);

    // Address wrap.
    do_load(rand_vec(), 4'd0, 11'h7FE, 1'b1);
    check_eq("d_addr0", 32'(out_addr), 32'h7FE);
    wait_idle("d_idle");

    // Dropped load, overflow flag, load coincident with done.
    do_load(rand_vec(), 4'd2, 11'h300, 1'b1);
    @(posedge clk); #1;
    ovf_clr = 1'b1;
    do_load(rand_vec(), 4'd5, 11'h000, 1'b0);
    ovf_clr = 1'b0;
    check_eq("e_ovf_set", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check_eq("e_ovf_clr", 32'(ovf), 32'd0);
    n = 0;
    while (!done && n < 20) begin @(posedge clk); #1; n++; end
    check_eq("e_done_seen", 32'(done), 32'd1);
    do_load(rand_vec(), 4'd4, 11'h400, 1'b1);
    check_eq("e_coincident_accept", 32'(busy), 32'd1);
    check_eq("e_ovf_quiet",         32'(ovf),  32'd0);
    wait_idle("e_idle");

    // Reset in the middle of a drain.
    do_load(rand_vec(), 4'd4, 11'h050, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_eq("f_valid", 32'(out_valid), 32'd0);
    check_eq("f_busy",  32'(busy),      32'd0);
    check_eq("f_done",  32'(done),      32'd0);
    check_eq("f_words_left", 32'(sb.size()), 32'd2);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    hs_cnt = 0;
    do_load(rand_vec(), 4'd1, 11'h060, 1'b1);
    check_eq("f_restart_addr", 32'(out_addr), 32'h060);
    wait_idle("f_idle");
    check_eq("f_hs", 32'(hs_cnt), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
